// File: rtl/pht_update_queue.sv
// Commit-side queue that buffers resolved branches and drains one PHT update per cycle.
// Optional gshare indexing is enabled by defining PHT_GSHARE_EN.
module pht_update_queue (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       commit_valid,
  input  logic [1:0][31:0] commit_pc,
  input  logic [1:0]       commit_taken,
  output logic             commit_ready,
  output logic             update_en,
  output logic [7:0]       index_up,
  output logic             taken_actual,
  output logic [3:0]       occupancy,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned DRP_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             taken;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [DRP_W-1:0]   drops;

  logic [IDX_W-1:0]   idx0;
  logic [IDX_W-1:0]   idx1;
  logic [PTR_W-1:0]   wr_ptr1;
  logic [1:0]         n_in;
  logic [1:0]         n_acc;
  logic [CNT_W-1:0]   count_nxt;
  logic [DRP_W:0]     drop_sum;
  logic [DRP_W-1:0]   drops_nxt;
  entry_t             head_e;

  // PC bits outside [9:2] never participate in indexing
  logic unused_pc_bits;
  assign unused_pc_bits = ^{commit_pc[0][31:10], commit_pc[0][1:0],
                            commit_pc[1][31:10], commit_pc[1][1:0]};

`ifdef PHT_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] ghr_nxt;

  // Lane 1 sees lane 0's outcome already shifted in when both are accepted
  always_comb begin
    idx0    = commit_pc[0][9:2] ^ ghr;
    idx1    = commit_pc[1][9:2] ^ (commit_valid[0] ? {ghr[IDX_W-2:0], commit_taken[0]} : ghr);
    ghr_nxt = ghr;
    if (commit_ready) begin
      case (commit_valid)
        2'b01:   ghr_nxt = {ghr[IDX_W-2:0], commit_taken[0]};
        2'b10:   ghr_nxt = {ghr[IDX_W-2:0], commit_taken[1]};
        2'b11:   ghr_nxt = {ghr[IDX_W-3:0], commit_taken[0], commit_taken[1]};
        default: ghr_nxt = ghr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ghr <= '0;
    else     ghr <= ghr_nxt;
  end
`else
  always_comb begin
    idx0 = commit_pc[0][9:2];
    idx1 = commit_pc[1][9:2];
  end
`endif

  assign commit_ready = (count <= CNT_W'(DEPTH - 2));
  assign update_en    = (count != '0);
  assign head_e       = mem[head];
  assign index_up     = update_en ? head_e.index : '0;
  assign taken_actual = update_en & head_e.taken;
  assign occupancy    = count;
  assign drop_cnt     = drops;

  // Occupancy and saturating drop accounting
  always_comb begin
    n_in      = 2'({1'b0, commit_valid[0]}) + 2'({1'b0, commit_valid[1]});
    n_acc     = commit_ready ? n_in : 2'd0;
    wr_ptr1   = commit_valid[0] ? tail + PTR_W'(1) : tail;
    count_nxt = count + CNT_W'(n_acc) - CNT_W'(update_en);
    drop_sum  = {1'b0, drops} + (commit_ready ? (DRP_W+1)'(0) : (DRP_W+1)'(n_in));
    drops_nxt = drop_sum[DRP_W] ? '1 : drop_sum[DRP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drops <= '0;
    end else begin
      head  <= head + PTR_W'(update_en);
      tail  <= tail + PTR_W'(n_acc);
      count <= count_nxt;
      drops <= drops_nxt;
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone
  always_ff @(posedge clk) begin
    if (!rst && commit_ready) begin
      if (commit_valid[0]) mem[tail]    <= '{index: idx0, taken: commit_taken[0]};
      if (commit_valid[1]) mem[wr_ptr1] <= '{index: idx1, taken: commit_taken[1]};
    end
  end

endmodule

// File: tb/tb_pht_update_queue.sv
// Directed table-driven bench for pht_update_queue, plus drop saturation and history sequences.
module tb_pht_update_queue;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       commit_valid;
  logic [1:0][31:0] commit_pc;
  logic [1:0]       commit_taken;
  logic             commit_ready;
  logic             update_en;
  logic [7:0]       index_up;
  logic             taken_actual;
  logic [3:0]       occupancy;
  logic [7:0]       drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pht_update_queue dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_taken (commit_taken),
    .commit_ready (commit_ready),
    .update_en    (update_en),
    .index_up     (index_up),
    .taken_actual (taken_actual),
    .occupancy    (occupancy),
    .drop_cnt     (drop_cnt)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [31:0] pc0;
    logic        t0;
    logic [31:0] pc1;
    logic        t1;
    logic        e_ready;
    logic        e_upd;
    logic [7:0]  e_idx;
    logic        e_tk;
    logic [3:0]  e_occ;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [1:0] v, logic [31:0] pc0, logic t0,
                              logic [31:0] pc1, logic t1, logic e_ready, logic e_upd,
                              logic [7:0] e_idx, logic e_tk, logic [3:0] e_occ,
                              logic [7:0] e_drop);
    vec_t x;
    x.rst = r; x.v = v; x.pc0 = pc0; x.t0 = t0; x.pc1 = pc1; x.t1 = t1;
    x.e_ready = e_ready; x.e_upd = e_upd; x.e_idx = e_idx; x.e_tk = e_tk;
    x.e_occ = e_occ; x.e_drop = e_drop;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [31:0] pc0,
                       input logic t0, input logic [31:0] pc1, input logic t1);
    rst             = r;
    commit_valid    = v;
    commit_pc[0]    = pc0;
    commit_pc[1]    = pc1;
    commit_taken[0] = t0;
    commit_taken[1] = t1;
  endtask

  logic [7:0] a2, a3, a5;
  logic [7:0] g_exp [3];

  initial begin
`ifdef PHT_GSHARE_EN
    a2 = 8'h41; a3 = 8'h82; a5 = 8'hFA;
    g_exp[0] = 8'h40; g_exp[1] = 8'h41; g_exp[2] = 8'h43;
`else
    a2 = 8'h40; a3 = 8'h80; a5 = 8'hFF;
    g_exp[0] = 8'h40; g_exp[1] = 8'h40; g_exp[2] = 8'h40;
`endif
    // reset state
    tbl.push_back(mk(1, 2'b00, 32'h0,   0, 32'h0,   0, 1, 0, 8'h00, 0, 4'd0, 8'd0));
    // single lane-0 commit, then dual commit, then lone lane 1
    tbl.push_back(mk(0, 2'b01, 32'h104, 1, 32'h0,   0, 1, 1, 8'h41, 1, 4'd1, 8'd0));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 0, 8'h00, 0, 4'd0, 8'd0));
    tbl.push_back(mk(0, 2'b11, 32'h100, 0, 32'h200, 1, 1, 1, a2,    0, 4'd2, 8'd0));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 1, a3,    1, 4'd1, 8'd0));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 0, 8'h00, 0, 4'd0, 8'd0));
    tbl.push_back(mk(0, 2'b10, 32'h0,   0, 32'h3FC, 0, 1, 1, a5,    0, 4'd1, 8'd0));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 0, 8'h00, 0, 4'd0, 8'd0));
    tbl.push_back(mk(1, 2'b00, 32'h0,   0, 32'h0,   0, 1, 0, 8'h00, 0, 4'd0, 8'd0));
    // back-to-back dual commits into overflow, then drain with pointer wrap
    tbl.push_back(mk(0, 2'b11, 32'h040, 0, 32'h044, 0, 1, 1, 8'h10, 0, 4'd2, 8'd0));
    tbl.push_back(mk(0, 2'b11, 32'h080, 0, 32'h084, 0, 1, 1, 8'h11, 0, 4'd3, 8'd0));
    tbl.push_back(mk(0, 2'b11, 32'h0C0, 0, 32'h0C4, 0, 1, 1, 8'h20, 0, 4'd4, 8'd0));
    tbl.push_back(mk(0, 2'b11, 32'h100, 0, 32'h104, 0, 1, 1, 8'h21, 0, 4'd5, 8'd0));
    tbl.push_back(mk(0, 2'b11, 32'h140, 0, 32'h144, 0, 1, 1, 8'h30, 0, 4'd6, 8'd0));
    tbl.push_back(mk(0, 2'b11, 32'h180, 0, 32'h184, 0, 0, 1, 8'h31, 0, 4'd7, 8'd0));
    tbl.push_back(mk(0, 2'b11, 32'h1C0, 0, 32'h1C4, 0, 1, 1, 8'h40, 0, 4'd6, 8'd2));
    tbl.push_back(mk(0, 2'b11, 32'h200, 0, 32'h204, 0, 0, 1, 8'h41, 0, 4'd7, 8'd2));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 1, 8'h50, 0, 4'd6, 8'd2));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 1, 8'h51, 0, 4'd5, 8'd2));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 1, 8'h60, 0, 4'd4, 8'd2));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 1, 8'h61, 0, 4'd3, 8'd2));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 1, 8'h80, 0, 4'd2, 8'd2));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 1, 8'h81, 0, 4'd1, 8'd2));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 0, 8'h00, 0, 4'd0, 8'd2));
    // fill to five entries, then reset (with commits present) discards everything
    tbl.push_back(mk(0, 2'b11, 32'h040, 0, 32'h044, 0, 1, 1, 8'h10, 0, 4'd2, 8'd2));
    tbl.push_back(mk(0, 2'b11, 32'h080, 0, 32'h084, 0, 1, 1, 8'h11, 0, 4'd3, 8'd2));
    tbl.push_back(mk(0, 2'b11, 32'h0C0, 0, 32'h0C4, 0, 1, 1, 8'h20, 0, 4'd4, 8'd2));
    tbl.push_back(mk(0, 2'b11, 32'h100, 0, 32'h104, 0, 1, 1, 8'h21, 0, 4'd5, 8'd2));
    tbl.push_back(mk(1, 2'b11, 32'h040, 0, 32'h044, 0, 1, 0, 8'h00, 0, 4'd0, 8'd0));
    tbl.push_back(mk(0, 2'b00, 32'h0,   0, 32'h0,   0, 1, 0, 8'h00, 0, 4'd0, 8'd0));

    drive(1, 2'b00, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].pc0, tbl[i].t0, tbl[i].pc1, tbl[i].t1);
      @(negedge clk);
      chk("commit_ready", i, 32'(commit_ready), 32'(tbl[i].e_ready));
      chk("update_en",    i, 32'(update_en),    32'(tbl[i].e_upd));
      chk("index_up",     i, 32'(index_up),     32'(tbl[i].e_idx));
      chk("taken_actual", i, 32'(taken_actual), 32'(tbl[i].e_tk));
      chk("occupancy",    i, 32'(occupancy),    32'(tbl[i].e_occ));
      chk("drop_cnt",     i, 32'(drop_cnt),     32'(tbl[i].e_drop));
    end

    // drop counter saturation: dual commits every cycle drop 2 on every other cycle from cycle 7
    drive(1, 2'b00, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    for (int c = 1; c <= 263; c++) begin
      drive(0, 2'b11, 32'h100, 0, 32'h104, 0);
      @(negedge clk);
      if (c == 259) begin
        chk("sat_drop_254", c, 32'(drop_cnt), 32'd254);
        chk("sat_occ_6",    c, 32'(occupancy), 32'd6);
      end
      if (c == 260) begin
        chk("sat_ready_0",  c, 32'(commit_ready), 32'd0);
        chk("sat_hold_254", c, 32'(drop_cnt), 32'd254);
      end
      if (c == 261) chk("sat_drop_255", c, 32'(drop_cnt), 32'd255);
      if (c == 263) chk("sat_stay_255", c, 32'(drop_cnt), 32'd255);
    end
    drive(0, 2'b00, 32'h0, 0, 32'h0, 0);
    repeat (8) @(negedge clk);
    chk("sat_drained", 0, 32'(occupancy), 32'd0);
    chk("sat_kept",    0, 32'(drop_cnt), 32'd255);

    // three taken commits at the same PC: history changes the index in the gshare build
    drive(1, 2'b00, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b01, 32'h100, 1, 32'h0, 0);
      @(negedge clk);
      chk("hist_upd", i, 32'(update_en),    32'd1);
      chk("hist_idx", i, 32'(index_up),     32'(g_exp[i]));
      chk("hist_tk",  i, 32'(taken_actual), 32'd1);
      chk("hist_occ", i, 32'(occupancy),    32'd1);
    end
    drive(0, 2'b00, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("hist_empty", 3, 32'(update_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pht_update_queue.md
PHT_UPDATE_QUEUE -- requirements
Module: pht_update_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have port commit_valid, input, [1:0]: a resolved conditional branch is present on each lane; lane 0 is older.
REQ-004 SHALL have port commit_pc, input, [1:0][31:0]: branch PC per lane.
REQ-005 SHALL have port commit_taken, input, [1:0]: resolved direction per lane.
REQ-006 SHALL have port commit_ready, output, 1 bit: the queue can accept two branches this cycle.
REQ-007 SHALL have port update_en, output, 1 bit: a PHT update is presented this cycle.
REQ-008 SHALL have port index_up, output, [7:0]: PHT index for the update.
REQ-009 SHALL have port taken_actual, output, 1 bit: resolved direction for the update.
REQ-010 SHALL have port occupancy, output, [3:0]: current entry count, 0..8.
REQ-011 SHALL have port drop_cnt, output, [7:0]: number of branches lost to overflow, saturating.

Function
REQ-012 SHALL hold an 8-entry circular FIFO of {index[7:0], taken} with 3-bit head/tail pointers that wrap 7->0, and a 4-bit count.
REQ-013 SHALL drive commit_ready = (count <= 6) combinationally from registered count.
REQ-014 SHALL enqueue, when commit_ready=1, valid lanes in program order: lane 0 at tail, then lane 1 at the next slot; a lone lane-1 valid goes to tail.
REQ-015 SHALL compute the entry index at enqueue as commit_pc[9:2], unless modified per REQ-024.
REQ-016 SHALL drop all valid lanes when commit_ready=0, leave FIFO unchanged, and add the dropped-lane count (1 or 2) to drop_cnt, saturating at 255.
REQ-017 SHALL drive update_en = (count != 0), with index_up and taken_actual taken from the head entry; all three are 0 when empty.
REQ-018 SHALL dequeue the head every cycle update_en=1; the PHT consumer has no backpressure.
REQ-019 SHALL give a minimum latency of 1 cycle: a branch accepted at edge N is presented at update_en in the cycle after edge N; no same-cycle bypass.
REQ-020 SHALL handle simultaneous enqueue and dequeue as count_next = count + n_enq - deq; full (8) with a dequeue and 2 incoming is impossible because ready requires count <= 6.
REQ-021 SHALL drain one entry per cycle in FIFO order, so entry order on update_en matches commit order exactly.
REQ-022 SHALL present occupancy = count.

Reset
REQ-023 SHALL, while rst=1 at an edge, clear head, tail, count, drop_cnt, and history to 0; outputs then read update_en=0, index_up=0, taken_actual=0, occupancy=0, and commit_ready=1. Reset mid-operation SHALL discard all queued entries without emitting them.

Configuration
REQ-024 SHALL, with macro PHT_GSHARE_EN defined, keep an 8-bit global history register (GHR).
- Lane 0 index = pc[9:2] ^ GHR.
- Lane 1 index = pc[9:2] ^ {GHR[6:0], lane-0 taken} when lane 0 is also enqueued, else pc[9:2] ^ GHR.
- The GHR shifts left, inserting taken at bit 0, once per accepted branch.
- Dropped branches SHALL NOT update the GHR.
REQ-025 SHALL, without PHT_GSHARE_EN, use index = pc[9:2] with no GHR state and identical timing.

Verification
REQ-026 SHALL cover: single lane-0 commit with pc=0x0000_0104 and taken=1 -> next cycle update_en=1, index_up=0x41, taken_actual=1; following cycle update_en=0.
REQ-027 SHALL cover: both lanes valid with pc0=0x100 taken=0 and pc1=0x200 taken=1 -> two consecutive update cycles with index 0x40/taken 0 and then 0x80/taken 1.
REQ-028 SHALL cover: dual commits every cycle for 6 cycles -> commit_ready falls once count reaches 7, later lanes are dropped, drop_cnt counts the dropped lanes, and no entry is corrupted or reordered.
REQ-029 SHALL cover: rst asserted with count=5 -> next cycle occupancy=0, update_en=0, drop_cnt=0.
REQ-030 SHALL cover, with PHT_GSHARE_EN: three taken commits at pc=0x100 -> indices 0x40, 0x41, 0x43.
REQ-031 SHALL cover: drop_cnt at 254 with a 2-lane drop -> drop_cnt=255 and it stays 255 on further drops.
